// File: rtl/fifo_ctrl_pkg.sv
// Shared state type, sizing helpers and default sizes
// for the FIFO write arbiter and its round-robin picker.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int DEPTH_DEF = 8;
  localparam int CRED_W    = cred_w(DEPTH_DEF);
  localparam int PTR_W     = ptr_w(N_REQ_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible
// requester scanning upward from start, with wrap.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = PTR_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    start,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [N_REQ-1:0] elig;

  assign elig = req & mask;

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(start) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && elig[PW'(j)]) begin
        valid          = 1'b1;
        idx            = PW'(j);
        onehot[PW'(j)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited write arbiter for a shared
// SyncFIFO write port, with its own free-entry credit count.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_FIFO = DEPTH_DEF,
  parameter int BURST_LEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_cs,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_pop,
  output logic [$clog2(DEPTH_FIFO):0] credits,
  output logic                        err_underflow
);

  localparam int CW = cred_w(DEPTH_FIFO);
  localparam int PW = ptr_w(N_REQ);
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [BW-1:0] BL_V   = BW'(BURST_LEN);
  localparam logic [CW-1:0] FULL_V = CW'(DEPTH_FIFO);

  state_e state_q, state_d;

  logic [PW-1:0]         owner_q, owner_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic                  err_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  cred_ok;
  logic                  cred_full;
  logic                  pop_ok;
  logic                  acc;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         owner_inc;
  logic [PW-1:0]         pick_inc;
  logic [PW-1:0]         pick_start;
  logic [N_REQ-1:0]      own_oh;
  logic [N_REQ-1:0]      pick_oh;
  logic [PW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [DATA_WIDTH-1:0] slot [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cred_ok   = (cred_q != '0);
  assign cred_full = (cred_q == FULL_V);
  assign pop_ok    = fifo_pop && !cred_full;
  assign owner_inc = PW'(wrap_inc(int'(owner_q), N_REQ));
  assign pick_inc  = PW'(wrap_inc(int'(pick_idx), N_REQ));
  assign own_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // On release the old owner becomes lowest priority.
  assign pick_start = (state_q == HOLD) ? owner_inc : rr_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .mask   ({N_REQ{cred_ok}}),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    gnt     = '0;
    win_idx = owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt     = pick_oh;
          win_idx = pick_idx;
          owner_d = pick_idx;
          burst_d = BW'(1);
          if (BURST_LEN > 1) state_d = HOLD;
          else               rr_d    = pick_inc;
        end
      end
      HOLD: begin
        if (cred_ok) begin
          if (req[owner_q] && burst_q < BL_V) begin
            gnt     = own_oh;
            burst_d = burst_q + BW'(1);
          end else begin
            rr_d = owner_inc;
            if (pick_vld) begin
              gnt     = pick_oh;
              win_idx = pick_idx;
              owner_d = pick_idx;
              burst_d = BW'(1);
            end else begin
              state_d = IDLE;
              burst_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc = |gnt;

  always_comb begin
    cred_d = cred_q;
    unique case ({acc, pop_ok})
      2'b10:   cred_d = cred_q - CW'(1);
      2'b01:   cred_d = cred_q + CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      cred_q  <= FULL_V;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      cred_q  <= cred_d;
      we_q    <= acc;
      if (acc) data_q <= slot[win_idx];
      if (fifo_pop && cred_full) err_q <= 1'b1;
    end
  end

  assign fifo_wr_en    = we_q;
  assign fifo_cs       = we_q;
  assign fifo_data     = data_q;
  assign credits       = cred_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter
// against a tenure-based reference model.
module tb_fifo_wr_arbiter;
  import fifo_ctrl_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int BL    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              fifo_pop = 1'b0;
  logic [N-1:0]      gnt;
  logic              fifo_cs;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [CRED_W-1:0] credits;
  logic              err_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  int            m_cred, m_owner, m_cnt, m_ptr, last_w;
  bit            m_hold, m_err, m_we;
  logic [DW-1:0] m_data;
  bit            pend  [N];
  logic [DW-1:0] pdata [N];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .DEPTH_FIFO (DEPTH),
    .BURST_LEN  (BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_cs       (fifo_cs),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data     (fifo_data),
    .fifo_pop      (fifo_pop),
    .credits       (credits),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (((r >> ((start + k) % N)) & 1) != 0) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_cred = DEPTH; m_owner = 0; m_cnt = 0; m_ptr = 0;
    m_hold = 0; m_err = 0; m_we = 0; m_data = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic p,
                            input logic rs);
    int  w;
    bit  pop_ok;
    w = -1;
    if (rs) begin
      model_reset();
      last_w = -1;
      return;
    end
    if (m_cred > 0) begin
      if (!m_hold) begin
        w = first_from(m_ptr, r);
        if (w >= 0) begin
          m_owner = w; m_cnt = 1;
          if (BL > 1) m_hold = 1;
          else        m_ptr = (w + 1) % N;
        end
      end else if (r[m_owner] && m_cnt < BL) begin
        w = m_owner;
        m_cnt++;
      end else begin
        m_ptr = (m_owner + 1) % N;
        w = first_from(m_ptr, r);
        if (w >= 0) begin m_owner = w; m_cnt = 1; end
        else m_hold = 0;
      end
    end
    pop_ok = p && (m_cred != DEPTH);
    if (p && m_cred == DEPTH) m_err = 1;
    m_cred = m_cred - ((w >= 0) ? 1 : 0) + (pop_ok ? 1 : 0);
    m_we = (w >= 0);
    if (w >= 0) m_data = pdata[w];
    last_w = w;
  endtask

  task automatic tick(input logic p, input logic rs);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = pend[i];
      req_data[i*DW +: DW] = pdata[i];
    end
    req = r; fifo_pop = p; rst = rs;
    #1;
    chk("wr_en", fifo_wr_en, m_we);
    chk("cs", fifo_cs, m_we);
    chk("data", fifo_data, m_data);
    chk("credits", credits, m_cred);
    chk("err", err_underflow, m_err);
    model_step(r, p, rs);
    if (!rs) chk("gnt", gnt, (last_w < 0) ? 64'd0 : (64'd1 << last_w));
    @(posedge clk); #1;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdata[i] = '0; end
  endtask

  initial begin
    int ngr;
    clear_pend();
    last_w = -1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick(0, 0);

    // single requester until credits run out
    ngr = 0;
    pend[0] = 1;
    for (int k = 0; k < 10; k++) begin
      pdata[0] = 32'hA0 + k;
      tick(0, 0);
      if (last_w >= 0) ngr++;
    end
    chk("single_grants", ngr, 8);
    chk("single_cred0", credits, 0);
    tick(1, 0);
    chk("stall_pop_cred", credits, 1);
    tick(0, 0);
    chk("stall_resume", last_w, 0);

    // reset mid-burst with a write in flight
    tick(0, 0);
    tick(0, 1);
    chk("rst_we", fifo_wr_en, 0);
    chk("rst_cred", credits, DEPTH);

    // fairness, continuous pops
    for (int i = 0; i < N; i++) pend[i] = 1;
    for (int k = 0; k < 16; k++) begin
      pdata[(k / 2) % N] = $urandom;
      tick(1, 0);
      chk("fair_order", last_w, (k / 2) % N);
    end

    // early release
    tick(0, 1);
    clear_pend();
    pend[1] = 1;
    tick(0, 0);
    chk("early_first", last_w, 1);
    pend[1] = 0; pend[2] = 1;
    tick(0, 0);
    chk("early_rel", last_w, 2);

    // accept and pop together at credits=3, then underflow
    tick(0, 1);
    clear_pend();
    pend[0] = 1;
    repeat (5) tick(0, 0);
    chk("cred3", credits, 3);
    tick(1, 0);
    chk("acc_pop", credits, 3);
    pend[0] = 0;
    repeat (5) tick(1, 0);
    chk("drained", credits, DEPTH);
    tick(1, 0);
    chk("uflow_cred", credits, DEPTH);
    chk("uflow_err", err_underflow, 1);
    repeat (3) tick(0, 0);
    chk("uflow_sticky", err_underflow, 1);

    // randomized traffic
    tick(0, 1);
    clear_pend();
    for (int c = 0; c < 3000; c++) begin
      if (last_w >= 0) begin
        pend[last_w]  = ($urandom_range(0, 3) != 0);
        pdata[last_w] = $urandom;
      end
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1;
          pdata[i] = $urandom;
        end
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
